// File: rtl/uart_pkg.sv
// Constants and state encodings shared by the UART receive/transmit blocks.
package uart_pkg;

  localparam int unsigned DATA_WIDTH      = 8;
  localparam int unsigned CLK_FREQ_HZ     = 100_000_000;
  localparam int unsigned BAUD_RATE       = 9600;
  localparam int unsigned CLK_COUNTER_INV = CLK_FREQ_HZ / BAUD_RATE;
  // Four bit times of line silence before a partial message is reported.
  localparam int unsigned TIMEOUT_CYCLES  = 4 * CLK_COUNTER_INV;

  typedef enum logic [1:0] {
    RXC_OFF   = 2'd0,
    RXC_ARMED = 2'd1,
    RXC_STALL = 2'd2
  } rxc_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter, synchronous flush and a
// combinational head read; storage has no reset.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push_in,
  input  logic                     pop_in,
  input  logic                     flush_in,
  input  logic [DATA_WIDTH-1:0]    wdata_in,
  output logic [DATA_WIDTH-1:0]    head_out,
  output logic [FIFO_ADDR_WIDTH:0] count_out
);

  logic [DATA_WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;
  logic                       do_push, do_pop;

  assign do_push = push_in & ~flush_in;
  assign do_pop  = pop_in & ~flush_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
      count_d = count_q + (FIFO_ADDR_WIDTH+1)'(do_push) - (FIFO_ADDR_WIDTH+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A push into a full FIFO with a same-cycle pop reuses the slot being read.
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_in;
  end

  assign head_out  = mem_q[rd_ptr_q];
  assign count_out = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: gates uart_rx, buffers bytes in a FIFO and reports
// overrun and inter-byte idle timeout to the consumer.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH      = uart_pkg::DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned FIFO_ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES  = uart_pkg::TIMEOUT_CYCLES,
  parameter int unsigned TIMEOUT_WIDTH   = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     enable_in,
  input  logic                     flush_in,
  input  logic                     rx_done_in,
  input  logic [DATA_WIDTH-1:0]    rx_data_in,
  output logic                     rx_en_out,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [FIFO_ADDR_WIDTH:0] count_out,
  output logic                     overrun_out,
  input  logic                     clear_overrun_in,
  output logic                     timeout_out
);

  localparam logic [FIFO_ADDR_WIDTH:0] FifoFull = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [TIMEOUT_WIDTH-1:0] TmoLast  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  uart_pkg::rxc_state_e     state_q, state_d;
  logic                     done_q, new_byte, full, pop, push, overrun_set;
  logic                     rx_en_q, overrun_q, overrun_d, timeout_q, timeout_d;
  logic                     tmo_fired_q, tmo_fired_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;

  assign new_byte  = rx_done_in & ~done_q;
  assign valid_out = (count_out != '0);
  assign full      = (count_out == FifoFull);
  assign pop       = valid_out & ready_in;
  // While full (late ARMED cycle or STALL) a byte is kept only if a pop frees its slot.
  assign push = new_byte & (((state_q == uart_pkg::RXC_ARMED) & (~full | pop)) |
                            ((state_q == uart_pkg::RXC_STALL) & pop));
  assign overrun_set = new_byte & (state_q != uart_pkg::RXC_OFF) & ~push;

  sync_fifo #(
    .DATA_WIDTH      (DATA_WIDTH),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (push),
    .pop_in    (pop),
    .flush_in  (flush_in),
    .wdata_in  (rx_data_in),
    .head_out  (data_out),
    .count_out (count_out)
  );

  always_comb begin
    state_d = state_q;
    if (!enable_in) begin
      state_d = uart_pkg::RXC_OFF;
    end else if (flush_in) begin
      state_d = uart_pkg::RXC_ARMED;
    end else begin
      unique case (state_q)
        uart_pkg::RXC_OFF:   state_d = uart_pkg::RXC_ARMED;
        uart_pkg::RXC_ARMED: if (full) state_d = uart_pkg::RXC_STALL;
        uart_pkg::RXC_STALL: if (!full) state_d = uart_pkg::RXC_ARMED;
        default:             state_d = uart_pkg::RXC_OFF;
      endcase
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_set)           overrun_d = 1'b1;
    else if (clear_overrun_in) overrun_d = 1'b0;
  end

  // Counter saturates at its last value; the pulse fires on the following cycle, once.
  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    tmo_fired_d = tmo_fired_q;
    timeout_d   = 1'b0;
    if (flush_in || new_byte || !valid_out) begin
      tmo_cnt_d   = '0;
      tmo_fired_d = 1'b0;
    end else if (tmo_cnt_q == TmoLast) begin
      timeout_d   = ~tmo_fired_q;
      tmo_fired_d = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TIMEOUT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= uart_pkg::RXC_OFF;
      rx_en_q     <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      tmo_fired_q <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rx_en_q     <= (state_d == uart_pkg::RXC_ARMED);
      done_q      <= rx_done_in;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      tmo_fired_q <= tmo_fired_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign rx_en_out   = rx_en_q;
  assign overrun_out = overrun_q;
  assign timeout_out = timeout_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;
  localparam int TC    = 100;
  localparam int SOFF = 0, SARMED = 1, SSTALL = 2;

  logic       clk = 1'b0, rst_n = 1'b1, enable = 1'b0, flush = 1'b0;
  logic       rx_done = 1'b0, ready = 1'b0, clr_ovr = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en, valid, overrun, timeout;
  logic [7:0] data;
  logic [4:0] count;
  int         passed = 0, total = 0;

  // Reference model state
  logic [7:0] mq[$];
  int         m_st, m_idle;
  bit         m_done, m_ovr, m_pulse;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DATA_WIDTH      (8),
    .FIFO_DEPTH      (DEPTH),
    .FIFO_ADDR_WIDTH (4),
    .TIMEOUT_CYCLES  (TC),
    .TIMEOUT_WIDTH   (16)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .enable_in        (enable),
    .flush_in         (flush),
    .rx_done_in       (rx_done),
    .rx_data_in       (rx_data),
    .rx_en_out        (rx_en),
    .data_out         (data),
    .valid_out        (valid),
    .ready_in         (ready),
    .count_out        (count),
    .overrun_out      (overrun),
    .clear_overrun_in (clr_ovr),
    .timeout_out      (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++; if (rx_en !== 1'b0)   $display("FAIL reset_rx_en got %b want 0", rx_en);     else passed++;
    total++; if (valid !== 1'b0)   $display("FAIL reset_valid got %b want 0", valid);     else passed++;
    total++; if (count !== 5'd0)   $display("FAIL reset_count got %0d want 0", count);    else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout); else passed++;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_basic_capture();
    enable = 1'b1;
    total++; if (rx_en !== 1'b0) $display("FAIL en_latency_early got %b want 0", rx_en); else passed++;
    tick();
    total++; if (rx_en !== 1'b1) $display("FAIL en_latency got %b want 1", rx_en); else passed++;
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h43);
    total++; if (count !== 5'd3)  $display("FAIL basic_count got %0d want 3", count); else passed++;
    total++; if (data !== 8'h41)  $display("FAIL basic_head got %h want 41", data);  else passed++;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (data !== 8'(8'h41 + i) || valid !== 1'b1)
        $display("FAIL basic_drain[%0d] got %h/%b want %h/1", i, data, valid, 8'(8'h41 + i));
      else passed++;
      tick();
    end
    ready = 1'b0;
    total++; if (valid !== 1'b0) $display("FAIL basic_empty got %b want 0", valid); else passed++;
  endtask

  task automatic test_held_level();
    rx_data = 8'h55;
    rx_done = 1'b1;
    repeat (20) tick();
    rx_done = 1'b0;
    tick();
    total++; if (count !== 5'd1) $display("FAIL held_count got %0d want 1", count); else passed++;
    total++; if (data !== 8'h55) $display("FAIL held_head got %h want 55", data);   else passed++;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++; if (count !== 5'd0) $display("FAIL held_drain got %0d want 0", count); else passed++;
  endtask

  task automatic test_full_overrun();
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    total++; if (count !== 5'd16) $display("FAIL full_count got %0d want 16", count); else passed++;
    total++; if (rx_en !== 1'b0)  $display("FAIL full_rx_en got %b want 0", rx_en);   else passed++;
    send_byte(8'hFF);
    total++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun);       else passed++;
    total++; if (count !== 5'd16)  $display("FAIL ovr_count got %0d want 16", count);     else passed++;
    total++; if (data !== 8'h00)   $display("FAIL ovr_head got %h want 00", data);        else passed++;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++; if (count !== 5'd15)  $display("FAIL pop_count got %0d want 15", count);     else passed++;
    total++; if (data !== 8'h01)   $display("FAIL pop_head got %h want 01", data);        else passed++;
    tick();
    total++; if (rx_en !== 1'b1)   $display("FAIL rearm_rx_en got %b want 1", rx_en);     else passed++;
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    total++; if (overrun !== 1'b0) $display("FAIL ovr_clear got %b want 0", overrun);     else passed++;
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp;
    send_byte(8'h10);
    total++; if (count !== 5'd16) $display("FAIL pp_prefill got %0d want 16", count); else passed++;
    rx_data = 8'hAA;
    rx_done = 1'b1;
    ready   = 1'b1;
    tick();
    rx_done = 1'b0;
    ready   = 1'b0;
    total++; if (count !== 5'd16)  $display("FAIL pp_count got %0d want 16", count);   else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL pp_overrun got %b want 0", overrun); else passed++;
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'(i + 2) : 8'hAA;
      total++; if (data !== exp) $display("FAIL pp_drain[%0d] got %h want %h", i, data, exp); else passed++;
      tick();
    end
    ready = 1'b0;
    total++; if (valid !== 1'b0) $display("FAIL pp_empty got %b want 0", valid); else passed++;
  endtask

  task automatic test_timeout();
    int first, pulses;
    for (int r = 0; r < 2; r++) begin
      rx_data = 8'(8'h10 + r);
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      first  = 0;
      pulses = 0;
      for (int k = 1; k <= 150; k++) begin
        tick();
        if (timeout === 1'b1) begin
          pulses++;
          if (first == 0) first = k;
        end
      end
      total++; if (first != TC) $display("FAIL tmo_delay[%0d] got %0d want %0d", r, first, TC); else passed++;
      total++; if (pulses != 1) $display("FAIL tmo_pulses[%0d] got %0d want 1", r, pulses); else passed++;
    end
    total++; if (count !== 5'd2) $display("FAIL tmo_count got %0d want 2", count); else passed++;
    ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i));
    send_byte(8'hFF);
    ready = 1'b1;
    repeat (11) tick();
    ready = 1'b0;
    total++; if (count !== 5'd5)   $display("FAIL fl_pre_count got %0d want 5", count); else passed++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (count !== 5'd0)   $display("FAIL fl_count got %0d want 0", count);     else passed++;
    total++; if (valid !== 1'b0)   $display("FAIL fl_valid got %b want 0", valid);      else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL fl_overrun got %b want 1", overrun);  else passed++;
    total++; if (rx_en !== 1'b1)   $display("FAIL fl_rx_en got %b want 1", rx_en);      else passed++;
  endtask

  task automatic test_async_reset();
    send_byte(8'h21);
    send_byte(8'h22);
    rx_data = 8'h23;
    rx_done = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (count !== 5'd0)   $display("FAIL ar_count got %0d want 0", count);    else passed++;
    total++; if (valid !== 1'b0)   $display("FAIL ar_valid got %b want 0", valid);     else passed++;
    total++; if (rx_en !== 1'b0)   $display("FAIL ar_rx_en got %b want 0", rx_en);     else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL ar_overrun got %b want 0", overrun); else passed++;
    rx_done = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Cycle-level behavioural model: FIFO as a queue, timeout as idle age.
  task automatic model_step();
    bit nb, pop, acc, full;
    int n;
    logic [7:0] tmp;
    n    = mq.size();
    full = (n == DEPTH);
    nb   = rx_done && !m_done;
    pop  = (n != 0) && ready;
    acc  = nb && ((m_st == SARMED && (!full || pop)) || (m_st == SSTALL && pop));
    if (nb && m_st != SOFF && !acc) m_ovr = 1'b1;
    else if (clr_ovr)               m_ovr = 1'b0;
    if (flush) mq.delete();
    else begin
      if (pop) tmp = mq.pop_front();
      if (acc) mq.push_back(rx_data);
    end
    if (flush || nb || n == 0) m_idle = 0;
    else m_idle++;
    m_pulse = (m_idle == TC);
    if (!enable)                         m_st = SOFF;
    else if (flush || m_st == SOFF)      m_st = SARMED;
    else if (m_st == SARMED && full)     m_st = SSTALL;
    else if (m_st == SSTALL && !full)    m_st = SARMED;
    m_done = rx_done;
  endtask

  task automatic test_random();
    int phase;
    rst_n   = 1'b0;
    enable  = 1'b0;
    rx_done = 1'b0;
    ready   = 1'b0;
    flush   = 1'b0;
    clr_ovr = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mq.delete();
    m_st = SOFF; m_idle = 0; m_done = 0; m_ovr = 0; m_pulse = 0;
    for (int i = 0; i < 1200; i++) begin
      phase   = i / 300;
      enable  = ($urandom_range(0, 31) != 0);
      flush   = ($urandom_range(0, 63) == 0);
      clr_ovr = ($urandom_range(0, 15) == 0);
      rx_data = 8'($urandom);
      case (phase)
        0:       begin rx_done = ($urandom_range(0, 1) == 0);   ready = ($urandom_range(0, 3) == 0);   end
        1:       begin rx_done = ($urandom_range(0, 1) == 0);   ready = ($urandom_range(0, 3) != 0);   end
        default: begin rx_done = ($urandom_range(0, 149) == 0); ready = ($urandom_range(0, 299) == 0);
                       enable = 1'b1; flush = 1'b0; end
      endcase
      model_step();
      tick();
      total++; if (rx_en !== (m_st == SARMED))
        $display("FAIL rand_rx_en cyc %0d got %b want %b", i, rx_en, (m_st == SARMED)); else passed++;
      total++; if (count !== 5'(mq.size()))
        $display("FAIL rand_count cyc %0d got %0d want %0d", i, count, mq.size()); else passed++;
      total++; if (valid !== (mq.size() != 0))
        $display("FAIL rand_valid cyc %0d got %b want %b", i, valid, (mq.size() != 0)); else passed++;
      if (mq.size() != 0) begin
        total++; if (data !== mq[0])
          $display("FAIL rand_data cyc %0d got %h want %h", i, data, mq[0]); else passed++;
      end
      total++; if (overrun !== m_ovr)
        $display("FAIL rand_overrun cyc %0d got %b want %b", i, overrun, m_ovr); else passed++;
      total++; if (timeout !== m_pulse)
        $display("FAIL rand_timeout cyc %0d got %b want %b", i, timeout, m_pulse); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_held_level();
    test_full_overrun();
    test_push_pop_full();
    test_timeout();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: passed %0d of %0d so far", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller that sits between `uart_rx` and the CPU's I/O port. It gates the receiver through `rx_en_out` and captures each completed byte into a FIFO. Bytes are handed to the consumer over a valid/ready handshake. The block also reports overrun and an inter-byte idle timeout, so software can drain partial messages.

## Interface
Parameters:
- `DATA_WIDTH`, 8, byte width; must match `uart_rx`.
- `FIFO_DEPTH`, 16, FIFO entries; must be a power of two.
- `FIFO_ADDR_WIDTH`, 4, log2(`FIFO_DEPTH`).
- `TIMEOUT_CYCLES`, 41664, idle clocks before a timeout is reported (4 bit times at 9600 baud, 100 MHz).
- `TIMEOUT_WIDTH`, 16, width of the timeout counter; must hold `TIMEOUT_CYCLES`.

Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset; asynchronous, active-low.
- `enable_in`  in  1  receive enable from the CPU.
- `flush_in`  in  1  synchronous FIFO flush, one-cycle pulse.
- `rx_done_in`  in  1  `done_receive_out` from `uart_rx`; a level signal.
- `rx_data_in`  in  `DATA_WIDTH`  `rxdata_out` from `uart_rx`.
- `rx_en_out`  out  1  drives `rx_en_in` of `uart_rx`.
- `data_out`  out  `DATA_WIDTH`  head-of-FIFO byte.
- `valid_out`  out  1  FIFO not empty.
- `ready_in`  in  1  consumer accepts `data_out`.
- `count_out`  out  `FIFO_ADDR_WIDTH+1`  occupancy, range 0..`FIFO_DEPTH`.
- `overrun_out`  out  1  sticky flag: a byte was dropped.
- `clear_overrun_in`  in  1  clears `overrun_out`.
- `timeout_out`  out  1  one-cycle idle-timeout pulse.

## Operation
- Byte event `new_byte` = `rx_done_in` & ~`done_q`.
  - `done_q` is a registered copy of `rx_done_in`.
  - Only rising edges count; a held level is one byte.
- State machine, held in a 2-bit state register:
  - **OFF**: `rx_en_out`=0; `new_byte` is ignored. Leave to ARMED when `enable_in`=1.
  - **ARMED**: `rx_en_out`=1; `new_byte` writes `rx_data_in` at `wr_ptr`. Go to STALL when `count_out` reaches `FIFO_DEPTH`.
  - **STALL**: `rx_en_out`=0; `new_byte` sets `overrun_out` and the byte is dropped. Return to ARMED when `count_out` falls below `FIFO_DEPTH`.
  - From any state, `enable_in`=0 forces OFF on the next edge. FIFO contents are kept.
- Read side:
  - `valid_out` = (`count_out` != 0).
  - `data_out` = `mem[rd_ptr]`, combinational read.
  - A pop occurs on `valid_out` & `ready_in`.
- Pointers are `FIFO_ADDR_WIDTH` bits and wrap modulo `FIFO_DEPTH`. Occupancy is `count_out`; there is no extra pointer bit.
- Push and pop in the same cycle:
  - Both take effect and `count_out` is unchanged.
  - A push while full with a simultaneous pop is accepted, not counted as overrun.
- `flush_in`:
  - Zeroes both pointers and `count_out`.
  - Clears the timeout counter.
  - Leaves `overrun_out` and the state unchanged, except STALL→ARMED when `enable_in`=1.
  - It wins over a push or pop in the same cycle.
- `overrun_out`: set has priority over `clear_overrun_in` in the same cycle.
- Timeout counter:
  - Reloads to 0 on `new_byte`.
  - Increments while `count_out` != 0 and no `new_byte`.
  - When it reaches `TIMEOUT_CYCLES-1`, `timeout_out` pulses for one cycle and the counter saturates.
  - It re-arms on the next `new_byte`, or when `count_out` returns to 0, which also zeroes it.

## Timing
- Reset values:
  - State OFF.
  - `rx_en_out`=0, `valid_out`=0, `count_out`=0, `overrun_out`=0, `timeout_out`=0.
  - `data_out` = `mem[0]`; contents undefined, qualified by `valid_out`.
  - Pointers, `done_q` and the timeout counter all 0.
- Reset asserted mid-operation clears everything above immediately, asynchronously.
- Enable and state latency:
  - `enable_in` rising at edge N gives `rx_en_out`=1 after edge N+1.
  - The state transition and `rx_en_out` are registered.
- Push latency: `rx_done_in` rising before edge N means the write happens at edge N, with `valid_out`, `count_out` and `data_out` valid after edge N.
- Full flow control:
  - The push filling entry `FIFO_DEPTH` makes STALL active after the next edge.
  - `rx_en_out` drops one cycle after full. A byte arriving in that window is accepted only if a pop frees space; otherwise it is an overrun.
- A pop at edge N updates `data_out` and `count_out` after edge N.

## Structure
- Shared package/header `uart_pkg`: state encodings `RXC_OFF`=2'd0, `RXC_ARMED`=2'd1, `RXC_STALL`=2'd2, plus the default `DATA_WIDTH` and baud-derived constants (`CLK_COUNTER_INV`, `TIMEOUT_CYCLES`) shared with `uart_rx`/`uart_tx`.
- One sub-module, `sync_fifo`:
  - Parameters `DATA_WIDTH`, `FIFO_DEPTH`, `FIFO_ADDR_WIDTH`.
  - Ports: push, pop, flush, count, combinational head.
  - Storage is distributed RAM without reset.
- FSM, edge detect, overrun and timeout logic live in `uart_rx_ctrl`.

## Test plan
- **Basic capture**: enable, then 3 `rx_done_in` pulses with 0x41, 0x42, 0x43, `ready_in`=0 → `count_out`=3, `data_out`=0x41; raise `ready_in` → 0x41, 0x42, 0x43 on consecutive cycles, then `valid_out`=0.
- **Held level**: `rx_done_in` held high for 20 cycles with 0x55 → exactly one entry, `count_out`=1.
- **Full and overrun**: 16 pushes 0x00..0x0F, no reads → STALL, `rx_en_out`=0; a 17th pulse 0xFF → `overrun_out`=1, `count_out`=16. Pop one → ARMED next cycle, `rx_en_out`=1, head 0x01. Pulse `clear_overrun_in` → `overrun_out`=0.
- **Push and pop while full**: at `count_out`=16, `ready_in`=1 and `new_byte`=0xAA in the same cycle → `count_out`=16, no overrun, 0xAA is the tail.
- **Timeout**: push 0x10 with no reads, `TIMEOUT_CYCLES` set to 100 → a single `timeout_out` pulse exactly 100 cycles after the push, no repeat. A new byte restarts the count.
- **Flush and reset**: flush with 5 entries → `count_out`=0 and `overrun_out` kept. Assert `rst_in` low mid-burst → all outputs at reset values without waiting for a clock edge.
